univ_shift_reg_en_amisha: RTL and testbench

Parametrised successor of the single-bit enabled D flip-flop. It is a WIDTH-bit register with a clock enable and eight operating modes: hold, logical shifts, rotates, arithmetic shift, parallel load and synchronous clear. It is built in the two-segment style: a state register plus next-state logic. It is the general-purpose storage, shift and serialiser element for the sequential-circuit library.

---
 rtl/univ_shift_reg_en_amisha.sv | 101 ++++++++++
 tb/tb_univ_shift_reg_en_amisha.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_en_amisha.sv
// Universal WIDTH-bit shift register with clock enable: hold, logical shifts,
// rotates, arithmetic shift right, parallel load and synchronous clear.
module univ_shift_reg_en_amisha #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             en_amisha,
    input  logic [2:0]       ctrl_amisha,
    input  logic [WIDTH-1:0] d_amisha,
    input  logic             sin_r_amisha,
    input  logic             sin_l_amisha,
    output logic [WIDTH-1:0] q_amisha,
    output logic             sout_msb_amisha,
    output logic             sout_lsb_amisha,
    output logic             zero_amisha,
    output logic             last_out_amisha
);

    localparam logic [2:0] CTRL_HOLD = 3'b000;
    localparam logic [2:0] CTRL_SHL  = 3'b001;
    localparam logic [2:0] CTRL_SHR  = 3'b010;
    localparam logic [2:0] CTRL_LOAD = 3'b011;
    localparam logic [2:0] CTRL_ROL  = 3'b100;
    localparam logic [2:0] CTRL_ROR  = 3'b101;
    localparam logic [2:0] CTRL_ASR  = 3'b110;
    localparam logic [2:0] CTRL_CLR  = 3'b111;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_next_s;
    logic             last_out_r;
    logic             last_next_s;

    // State register: contents plus the most recently ejected bit.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            r_reg      <= RESET_VAL;
            last_out_r <= 1'b0;
        end else begin
            r_reg      <= r_next_s;
            last_out_r <= last_next_s;
        end
    end

    // Next-state decode; unknown or disabled control falls back to hold.
    always_comb begin
        r_next_s    = r_reg;
        last_next_s = last_out_r;
        if (en_amisha) begin
            case (ctrl_amisha)
                CTRL_HOLD: begin
                    r_next_s    = r_reg;
                    last_next_s = last_out_r;
                end
                CTRL_SHL: begin
                    r_next_s    = {r_reg[WIDTH-2:0], sin_r_amisha};
                    last_next_s = r_reg[WIDTH-1];
                end
                CTRL_SHR: begin
                    r_next_s    = {sin_l_amisha, r_reg[WIDTH-1:1]};
                    last_next_s = r_reg[0];
                end
                CTRL_LOAD: begin
                    r_next_s    = d_amisha;
                    last_next_s = last_out_r;
                end
                CTRL_ROL: begin
                    r_next_s    = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
                    last_next_s = r_reg[WIDTH-1];
                end
                CTRL_ROR: begin
                    r_next_s    = {r_reg[0], r_reg[WIDTH-1:1]};
                    last_next_s = r_reg[0];
                end
                CTRL_ASR: begin
                    r_next_s    = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
                    last_next_s = r_reg[0];
                end
                CTRL_CLR: begin
                    r_next_s    = {WIDTH{1'b0}};
                    last_next_s = 1'b0;
                end
                default: begin
                    r_next_s    = r_reg;
                    last_next_s = last_out_r;
                end
            endcase
        end else begin
            r_next_s    = r_reg;
            last_next_s = last_out_r;
        end
    end

    assign q_amisha        = r_reg;
    assign sout_msb_amisha = r_reg[WIDTH-1];
    assign sout_lsb_amisha = r_reg[0];
    assign zero_amisha     = (r_reg == {WIDTH{1'b0}});
    assign last_out_amisha = last_out_r;

endmodule

// File: tb/tb_univ_shift_reg_en_amisha.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// a WIDTH=16 build, and randomized traffic against an arithmetic model.
module tb_univ_shift_reg_en_amisha;

    logic        clk_amisha = 1'b0;
    logic        reset_amisha;
    logic        en_amisha;
    logic [2:0]  ctrl_amisha;
    logic [7:0]  d_amisha;
    logic        sin_r_amisha, sin_l_amisha;
    logic [7:0]  q_amisha;
    logic        sout_msb_amisha, sout_lsb_amisha, zero_amisha, last_out_amisha;

    logic        reset16;
    logic        en16;
    logic [2:0]  ctrl16;
    logic [15:0] d16;
    logic        sin_r16, sin_l16;
    logic [15:0] q16;
    logic        msb16, lsb16, zero16, last16;

    always #5 clk_amisha = ~clk_amisha;

    univ_shift_reg_en_amisha #(.WIDTH(8)) dut8 (
        .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .en_amisha(en_amisha),
        .ctrl_amisha(ctrl_amisha), .d_amisha(d_amisha), .sin_r_amisha(sin_r_amisha),
        .sin_l_amisha(sin_l_amisha), .q_amisha(q_amisha), .sout_msb_amisha(sout_msb_amisha),
        .sout_lsb_amisha(sout_lsb_amisha), .zero_amisha(zero_amisha),
        .last_out_amisha(last_out_amisha)
    );

    univ_shift_reg_en_amisha #(.WIDTH(16)) dut16 (
        .clk_amisha(clk_amisha), .reset_amisha(reset16), .en_amisha(en16),
        .ctrl_amisha(ctrl16), .d_amisha(d16), .sin_r_amisha(sin_r16),
        .sin_l_amisha(sin_l16), .q_amisha(q16), .sout_msb_amisha(msb16),
        .sout_lsb_amisha(lsb16), .zero_amisha(zero16), .last_out_amisha(last16)
    );

    typedef struct {
        logic       en;
        logic [2:0] ctrl;
        logic [7:0] d;
        logic       sr;
        logic       sl;
        logic [7:0] eq;
        logic       el;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] eq, input logic el);
        chk({nm, ".q"}, {8'h00, q_amisha}, {8'h00, eq});
        chk({nm, ".last"}, {15'h0, last_out_amisha}, {15'h0, el});
        chk({nm, ".zero"}, {15'h0, zero_amisha}, {15'h0, (eq == 8'h00)});
        chk({nm, ".msb"}, {15'h0, sout_msb_amisha}, {15'h0, eq[7]});
        chk({nm, ".lsb"}, {15'h0, sout_lsb_amisha}, {15'h0, eq[0]});
    endtask

    task automatic step8(input logic en, input logic [2:0] c, input logic [7:0] d,
                         input logic sr, input logic sl);
        @(negedge clk_amisha);
        en_amisha = en; ctrl_amisha = c; d_amisha = d;
        sin_r_amisha = sr; sin_l_amisha = sl;
        @(posedge clk_amisha);
        #1;
    endtask

    task automatic step16(input logic en, input logic [2:0] c, input logic [15:0] d,
                          input logic sr);
        @(negedge clk_amisha);
        en16 = en; ctrl16 = c; d16 = d; sin_r16 = sr; sin_l16 = 1'b0;
        @(posedge clk_amisha);
        #1;
    endtask

    // Reference model: each mode as integer arithmetic on an unsigned value.
    function automatic void model(input int w, input logic en, input logic [2:0] c,
                                  input logic [15:0] d, input logic sr, input logic sl,
                                  inout int q, inout int lo);
        int mask, msb, lsb;
        mask = (1 << w) - 1;
        msb  = (q >> (w - 1)) & 1;
        lsb  = q & 1;
        if (en) begin
            case (c)
                3'd1: begin q = ((q * 2) + int'(sr)) & mask; lo = msb; end
                3'd2: begin q = (q / 2) + (int'(sl) << (w - 1)); lo = lsb; end
                3'd3: q = int'(d) & mask;
                3'd4: begin q = ((q * 2) + msb) & mask; lo = msb; end
                3'd5: begin q = (q / 2) + (lsb << (w - 1)); lo = lsb; end
                3'd6: begin q = (q / 2) + (msb << (w - 1)); lo = lsb; end
                3'd7: begin q = 0; lo = 0; end
                default: ;
            endcase
        end
    endfunction

    initial begin
        int   mq, ml;
        vec_t v;

        reset_amisha = 1'b1; en_amisha = 1'b0; ctrl_amisha = 3'd0; d_amisha = 8'h00;
        sin_r_amisha = 1'b0; sin_l_amisha = 1'b0;
        reset16 = 1'b1; en16 = 1'b0; ctrl16 = 3'd0; d16 = 16'h0; sin_r16 = 1'b0; sin_l16 = 1'b0;
        #12;
        chk8("reset_init", 8'h00, 1'b0);
        reset_amisha = 1'b0; reset16 = 1'b0;

        // Asynchronous reset mid-cycle with a loaded, shifted value.
        step8(1'b1, 3'd3, 8'h4B, 1'b0, 1'b0);
        step8(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
        chk8("pre_reset", 8'hA5, 1'b1);
        #3;
        reset_amisha = 1'b1;
        #1;
        chk8("async_reset", 8'h00, 1'b0);
        @(negedge clk_amisha);
        en_amisha = 1'b0; ctrl_amisha = 3'd3; d_amisha = 8'hFF;
        #2;
        reset_amisha = 1'b0;
        @(posedge clk_amisha);
        #1;
        chk8("post_reset_hold", 8'h00, 1'b0);

        // Directed table; serial inputs are set to 1 where they must be ignored.
        tbl.push_back('{1'b1, 3'd3, 8'h96, 1'b1, 1'b1, 8'h96, 1'b0});
        tbl.push_back('{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 8'h00, 1'b1, 1'b1, 8'h2D, 1'b1});
        tbl.push_back('{1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 8'h16, 1'b1});
        tbl.push_back('{1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h16, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1});
        tbl.push_back('{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 8'h81, 1'b1});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b1, 1'b1, 8'h60, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h18, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0});
        tbl.push_back('{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 8'h90, 1'b0, 1'b0, 8'h90, 1'b0});
        tbl.push_back('{1'b1, 3'd6, 8'h00, 1'b1, 1'b0, 8'hC8, 1'b0});
        tbl.push_back('{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hE4, 1'b0});
        tbl.push_back('{1'b1, 3'd7, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step8(v.en, v.ctrl, v.d, v.sr, v.sl);
            chk8($sformatf("vec%0d", i), v.eq, v.el);
        end

        // Arithmetic shift right of a negative value saturates at all-ones.
        step8(1'b1, 3'd3, 8'hE4, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step8(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
            chk("asr_nonzero", {15'h0, zero_amisha}, 16'h0000);
        end
        chk8("asr_saturate", 8'hFF, 1'b1);

        // WIDTH logical shifts with zero serial input empty the register.
        for (int i = 0; i < 8; i++) step8(1'b1, 3'd1, 8'h00, 1'b0, 1'b1);
        chk8("shl_to_zero", 8'h00, 1'b1);

        // WIDTH=16 build: load, clear, then fill with ones from the right.
        step16(1'b1, 3'd3, 16'hBEEF, 1'b0);
        chk("w16_load", q16, 16'hBEEF);
        step16(1'b1, 3'd7, 16'h0000, 1'b1);
        chk("w16_clear", q16, 16'h0000);
        chk("w16_zero", {15'h0, zero16}, 16'h0001);
        chk("w16_last", {15'h0, last16}, 16'h0000);
        for (int i = 0; i < 16; i++) step16(1'b1, 3'd1, 16'h0000, 1'b1);
        chk("w16_fill", q16, 16'hFFFF);
        chk("w16_msb_lsb", {14'h0, msb16, lsb16}, 16'h0003);
        chk("w16_fill_last", {15'h0, last16}, 16'h0000);
        for (int i = 0; i < 16; i++) step16(1'b1, 3'd4, 16'h0000, 1'b0);
        chk("w16_rotate_full", q16, 16'hFFFF);

        // Randomized traffic against the model.
        mq = int'(q_amisha); ml = int'(last_out_amisha);
        for (int i = 0; i < 400; i++) begin
            logic       ren, rsr, rsl;
            logic [2:0] rc;
            logic [7:0] rd;
            ren = ($urandom_range(0, 3) != 0);
            rc  = 3'($urandom_range(0, 7));
            rd  = 8'($urandom);
            rsr = 1'($urandom);
            rsl = 1'($urandom);
            model(8, ren, rc, {8'h00, rd}, rsr, rsl, mq, ml);
            step8(ren, rc, rd, rsr, rsl);
            chk8("rand", 8'(mq), 1'(ml));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
